// File: rtl/saturn_alu_field_sequencer_pkg.sv
// Shared definitions for the ALU field sequencer: field codes, states, width.
package saturn_alu_field_sequencer_pkg;

  // Register width in nibbles; nibble pointers are always 4 bits wide.
  localparam int SAT_NIBBLES = 16;

  typedef enum logic [3:0] {
    F_P  = 4'd0,
    F_WP = 4'd1,
    F_XS = 4'd2,
    F_X  = 4'd3,
    F_S  = 4'd4,
    F_M  = 4'd5,
    F_B  = 4'd6,
    F_W  = 4'd7,
    F_A  = 4'd8
  } field_e;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/saturn_alu_field_sequencer_field_decode.sv
// Field code -> nibble range decoder; shared with the disassembler/debug path.
module saturn_field_decode
  import saturn_alu_field_sequencer_pkg::*;
(
  input  logic [3:0] i_field,
  input  logic [3:0] i_reg_p,
  output logic [3:0] o_start,
  output logic [3:0] o_end,
  output logic       o_valid
);

  // Map each field to its start/end nibble; codes 9-15 are flagged invalid.
  always_comb begin
    o_start = 4'd0;
    o_end   = 4'd0;
    o_valid = 1'b1;
    case (i_field)
      F_P:  begin o_start = i_reg_p; o_end = i_reg_p; end
      F_WP: begin o_start = 4'd0;    o_end = i_reg_p; end
      F_XS: begin o_start = 4'd2;    o_end = 4'd2;    end
      F_X:  begin o_start = 4'd0;    o_end = 4'd2;    end
      F_S:  begin o_start = 4'd15;   o_end = 4'd15;   end
      F_M:  begin o_start = 4'd3;    o_end = 4'd14;   end
      F_B:  begin o_start = 4'd0;    o_end = 4'd1;    end
      F_W:  begin o_start = 4'd0;    o_end = 4'd15;   end
      F_A:  begin o_start = 4'd0;    o_end = 4'd4;    end
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/saturn_alu_field_sequencer.sv
// Nibble-pointer sequencer for the ALU register file: clear walk after reset,
// then one field walk per decoded instruction, one nibble per 4-phase cycle.
module saturn_alu_field_sequencer
  import saturn_alu_field_sequencer_pkg::*;
#(
  parameter int NIBBLES       = SAT_NIBBLES,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_stalled,
  input  logic       i_phase_3,
  input  logic       i_start,
  input  logic [3:0] i_field,
  input  logic [3:0] i_reg_p,
  output logic       o_busy,
  output logic       o_alu_initializing,
  output logic [3:0] o_src_ptr,
  output logic [3:0] o_dest_ptr,
  output logic       o_first_nbl,
  output logic       o_last_nbl,
  output logic       o_reg_store_en,
  output logic       o_done,
  output logic       o_field_err
);

  localparam logic [3:0] LAST_PTR = 4'(NIBBLES - 1);

  state_e     r_state;
  logic [3:0] r_ptr;
  logic [3:0] r_start;
  logic [3:0] r_end;
  logic       r_done;
  logic       r_field_err;

  logic [3:0] w_dec_start;
  logic [3:0] w_dec_end;
  logic       w_dec_valid;
  logic       w_run;
  logic       w_step;

  saturn_field_decode u_decode (
    .i_field (i_field),
    .i_reg_p (i_reg_p),
    .o_start (w_dec_start),
    .o_end   (w_dec_end),
    .o_valid (w_dec_valid)
  );

  // Reset is gated in so an abandoned walk never stores or flags nibbles.
  assign w_run  = (r_state == ST_RUN) && !i_reset;
  assign w_step = w_run && i_phase_3 && !i_stalled;

  // Sequencer FSM: clear walk, idle/accept, field walk with phase-3 stepping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= INIT_ON_RESET ? ST_INIT : ST_IDLE;
      r_ptr       <= 4'd0;
      r_start     <= 4'd0;
      r_end       <= 4'd0;
      r_done      <= 1'b0;
      r_field_err <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_field_err <= 1'b0;
      case (r_state)
        // Clear walk runs every clock and ignores stall and start.
        ST_INIT: begin
          if (r_ptr == LAST_PTR) begin
            r_state <= ST_IDLE;
            r_ptr   <= 4'd0;
          end else begin
            r_ptr <= r_ptr + 4'd1;
          end
        end
        // P is captured here via the decoder; later P changes cannot leak in.
        ST_IDLE: begin
          if (i_start && !i_stalled) begin
            if (w_dec_valid) begin
              r_start <= w_dec_start;
              r_end   <= w_dec_end;
              r_ptr   <= w_dec_start;
              r_state <= ST_RUN;
            end else begin
              r_field_err <= 1'b1;
            end
          end
        end
        // Pointer holds through the cycle and advances only after the store.
        ST_RUN: begin
          if (i_phase_3 && !i_stalled) begin
            if (r_ptr == r_end) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_ptr <= r_ptr + 4'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy             = i_reset || (r_state != ST_IDLE);
  assign o_alu_initializing = !i_reset && (r_state == ST_INIT);
  assign o_src_ptr          = r_ptr;
  assign o_dest_ptr         = r_ptr;
  assign o_first_nbl        = w_run && (r_ptr == r_start);
  assign o_last_nbl         = w_run && (r_ptr == r_end);
  assign o_reg_store_en     = w_step;
  assign o_done             = r_done;
  assign o_field_err        = r_field_err;

endmodule

// File: tb/tb_saturn_alu_field_sequencer.sv
// Directed bench for the ALU field sequencer: vector table of field walks
// plus hand sequences for INIT, stall, P change, errors, back-to-back, reset.
module tb_saturn_alu_field_sequencer;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_stalled = 1'b0;
  logic       i_phase_3 = 1'b0;
  logic       i_start = 1'b0;
  logic [3:0] i_field = 4'd0;
  logic [3:0] i_reg_p = 4'd0;
  logic       o_busy, o_alu_initializing, o_first_nbl, o_last_nbl;
  logic       o_reg_store_en, o_done, o_field_err;
  logic [3:0] o_src_ptr, o_dest_ptr;

  saturn_alu_field_sequencer dut (
    .i_clk              (i_clk),
    .i_reset            (i_reset),
    .i_stalled          (i_stalled),
    .i_phase_3          (i_phase_3),
    .i_start            (i_start),
    .i_field            (i_field),
    .i_reg_p            (i_reg_p),
    .o_busy             (o_busy),
    .o_alu_initializing (o_alu_initializing),
    .o_src_ptr          (o_src_ptr),
    .o_dest_ptr         (o_dest_ptr),
    .o_first_nbl        (o_first_nbl),
    .o_last_nbl         (o_last_nbl),
    .o_reg_store_en     (o_reg_store_en),
    .o_done             (o_done),
    .o_field_err        (o_field_err)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // Free-running 4-phase cycle, advanced just after each rising edge.
  int ph = 0;
  always @(posedge i_clk) begin
    #1;
    ph = (ph + 1) % 4;
    i_phase_3 = (ph == 3);
  end

  // Monitor: log every store with its first/last flags, and count pulses.
  int cyc = 0;
  int st_ptr[$];
  bit st_first[$];
  bit st_last[$];
  int done_cnt = 0, err_cnt = 0, alias_bad = 0;
  int last_store_cyc = 0, done_cyc = 0;
  always @(negedge i_clk) begin
    cyc++;
    if (o_reg_store_en) begin
      st_ptr.push_back(int'(o_dest_ptr));
      st_first.push_back(o_first_nbl);
      st_last.push_back(o_last_nbl);
      last_store_cyc = cyc;
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (o_field_err) err_cnt++;
    if (o_dest_ptr !== o_src_ptr) alias_bad++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_log();
    st_ptr.delete();
    st_first.delete();
    st_last.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  task automatic issue_start(input logic [3:0] f, input logic [3:0] p);
    @(posedge i_clk); #2;
    i_field = f;
    i_reg_p = p;
    i_start = 1'b1;
    @(posedge i_clk); #2;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int k = 0; k < 400; k++) begin
      @(posedge i_clk);
      if (done_cnt >= n) break;
    end
    repeat (3) @(posedge i_clk);
  endtask

  // Compare the logged store sequence against the walk s..e.
  task automatic check_walk(input string name, input int s, input int e);
    int n;
    int bad;
    n = e - s + 1;
    bad = 0;
    chk({name, "_stores"}, st_ptr.size(), n);
    for (int k = 0; k < st_ptr.size() && k < n; k++) begin
      if (st_ptr[k] != s + k) bad++;
      if (st_first[k] != (k == 0)) bad++;
      if (st_last[k] != (k == n - 1)) bad++;
    end
    chk({name, "_seq"}, bad, 0);
    chk({name, "_done"}, done_cnt, 1);
    chk({name, "_done_lat"}, done_cyc - last_store_cyc, 1);
    chk({name, "_err"}, err_cnt, 0);
  endtask

  typedef struct {
    string      name;
    logic [3:0] field;
    logic [3:0] reg_p;
    int         exp_start;
    int         exp_end;
  } vec_t;

  vec_t vecs[$];
  bit   found;

  initial begin
    vecs.push_back('{"A",    4'd8, 4'd9,  0,  4});
    vecs.push_back('{"P5",   4'd0, 4'd5,  5,  5});
    vecs.push_back('{"P0",   4'd0, 4'd0,  0,  0});
    vecs.push_back('{"WP3",  4'd1, 4'd3,  0,  3});
    vecs.push_back('{"WP15", 4'd1, 4'd15, 0, 15});
    vecs.push_back('{"XS",   4'd2, 4'd7,  2,  2});
    vecs.push_back('{"X",    4'd3, 4'd7,  0,  2});
    vecs.push_back('{"S",    4'd4, 4'd0, 15, 15});
    vecs.push_back('{"M",    4'd5, 4'd1,  3, 14});
    vecs.push_back('{"B",    4'd6, 4'd1,  0,  1});
    vecs.push_back('{"W",    4'd7, 4'd1,  0, 15});

    // Reset values while reset is held.
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_busy", o_busy, 1);
    chk("rst_init", o_alu_initializing, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_field_err, 0);
    chk("rst_store", o_reg_store_en, 0);
    chk("rst_ptr", o_dest_ptr, 0);

    // Clear walk: 16 clocks, pointer 0..15, then idle.
    @(posedge i_clk); #2;
    i_reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge i_clk);
      chk($sformatf("init_flag_%0d", k), o_alu_initializing, 1);
      chk($sformatf("init_ptr_%0d", k), o_dest_ptr, k);
    end
    @(negedge i_clk);
    chk("init_end_flag", o_alu_initializing, 0);
    chk("init_end_busy", o_busy, 0);
    chk("init_end_ptr", o_dest_ptr, 0);

    // Table of field walks.
    foreach (vecs[i]) begin
      clear_log();
      issue_start(vecs[i].field, vecs[i].reg_p);
      wait_done(1);
      check_walk(vecs[i].name, vecs[i].exp_start, vecs[i].exp_end);
      chk({vecs[i].name, "_idle"}, o_busy, 0);
    end

    // WP with P=6, P changed to 2 mid-walk: walk still ends at 6.
    clear_log();
    issue_start(4'd1, 4'd6);
    repeat (6) @(posedge i_clk);
    #2 i_reg_p = 4'd2;
    wait_done(1);
    check_walk("wp_pchg", 0, 6);

    // M with stall across the phase 3 at ptr 7.
    clear_log();
    issue_start(4'd5, 4'd0);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge i_clk); #2;
      if (o_dest_ptr == 4'd7 && i_phase_3) begin
        found = 1'b1;
        break;
      end
    end
    chk("stall_reach7", found, 1);
    i_stalled = 1'b1;
    #1 chk("stall_no_store", o_reg_store_en, 0);
    @(posedge i_clk); #2;
    chk("stall_ptr_hold", o_dest_ptr, 7);
    i_stalled = 1'b0;
    wait_done(1);
    check_walk("m_stall", 3, 14);

    // Invalid field: single error pulse, no walk.
    clear_log();
    issue_start(4'd11, 4'd0);
    #1 chk("inv_busy", o_busy, 0);
    repeat (8) @(posedge i_clk);
    chk("inv_err", err_cnt, 1);
    chk("inv_stores", st_ptr.size(), 0);
    chk("inv_done", done_cnt, 0);

    // Back-to-back: XS started in the o_done cycle of an S walk.
    clear_log();
    issue_start(4'd4, 4'd0);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge i_clk); #2;
      if (o_done) begin
        found = 1'b1;
        break;
      end
    end
    chk("b2b_done_seen", found, 1);
    i_field = 4'd2;
    i_start = 1'b1;
    @(posedge i_clk); #2;
    i_start = 1'b0;
    chk("b2b_busy", o_busy, 1);
    chk("b2b_ptr", o_dest_ptr, 2);
    wait_done(2);
    chk("b2b_stores", st_ptr.size(), 2);
    chk("b2b_s_ptr", (st_ptr.size() > 0) ? st_ptr[0] : -1, 15);
    chk("b2b_xs_ptr", (st_ptr.size() > 1) ? st_ptr[1] : -1, 2);
    chk("b2b_done", done_cnt, 2);

    // Reset during a W walk at ptr 9: no store, no done, clear walk restarts.
    clear_log();
    issue_start(4'd7, 4'd0);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge i_clk); #2;
      if (o_dest_ptr == 4'd9 && i_phase_3) begin
        found = 1'b1;
        break;
      end
    end
    chk("rstw_reach9", found, 1);
    i_reset = 1'b1;
    #1 chk("rstw_no_store", o_reg_store_en, 0);
    @(posedge i_clk); #2;
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("rstw_init", o_alu_initializing, 1);
    chk("rstw_ptr", o_dest_ptr, 0);
    chk("rstw_stores", st_ptr.size(), 9);
    repeat (17) @(posedge i_clk);
    #2;
    chk("rstw_done", done_cnt, 0);
    chk("rstw_idle", o_busy, 0);
    chk("ptr_alias", alias_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
